// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the 9-bit processor instruction feeder: opcodes,
// FSM encoding and the word width also used by the processor control unit.
package instr_feeder_pkg;

  localparam int DATA_W_DEF = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_IMM   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  // Only mv/mvi/add/sub are issued; halt is handled locally, 100-110 are illegal.
  function automatic logic op_issuable(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/instr_feeder.sv
// Fetches instructions from a synchronous ROM and issues them one at a time to the
// processor (Run strobe + DIN word, mvi immediate on the following cycle), waiting for Done.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] din_o,
  output logic              run_o,
  input  logic              done_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        load_op;
  logic [ADDR_W-1:0] pc_plus1, pc_plus2;
  logic [CNT_W-1:0]  cnt_inc;

  assign load_op  = mem_data_i[DATA_W-1 -: 3];
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_plus2 = pc_q + ADDR_W'(2);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      din_q      <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= OP_MV;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      run_q      <= run_d;
      err_q      <= err_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered outputs are computed for the state being entered, so DIN/Run/MemAddr
  // hold the values belonging to the current state for its whole cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    din_d      = '0;
    run_d      = 1'b0;
    err_d      = err_q;
    op_d       = op_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          pc_d       = '0;
          mem_addr_d = '0;
          err_d      = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_addr_d = pc_plus1;
        state_d    = ST_LOAD;
      end

      ST_LOAD: begin
        op_d = load_op;
        if (load_op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (op_issuable(load_op)) begin
          din_d   = mem_data_i;
          run_d   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_ISSUE: begin
        // ROM now returns the word at PC+1, which is the mvi immediate.
        cnt_d = '0;
        if (op_q == OP_MVI) begin
          din_d   = mem_data_i;
          state_d = ST_IMM;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_IMM: begin
        if (done_i) begin
          pc_d       = pc_plus2;
          mem_addr_d = pc_plus2;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (done_i) begin
          pc_d       = (op_q == OP_MVI) ? pc_plus2 : pc_plus1;
          mem_addr_d = (op_q == OP_MVI) ? pc_plus2 : pc_plus1;
          state_d    = ST_FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr_o = mem_addr_q;
  assign din_o      = din_q;
  assign run_o      = run_q;
  assign pc_o       = pc_q;
  assign error_o    = err_q;
  assign halted_o   = (state_q == ST_HALT);
  assign busy_o     = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_ISSUE)
                   || (state_q == ST_IMM)   || (state_q == ST_WAIT);

endmodule
